error_sequencer: RTL and testbench

ERROR_SEQUENCER -- requirements
Module: ERROR_SEQUENCER

---
 rtl/error_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_error_sequencer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/error_sequencer.sv
// Staged Y -> X -> Z alignment sequencer: turns sign-magnitude position/heading
// errors into saturated velocity commands, with settle, timeout and re-entry logic.
module error_sequencer #(
   parameter int unsigned          N_WIDTH   = 32,
   parameter int unsigned          Q_WIDTH   = 15,
   parameter logic [N_WIDTH-1:0]   H_Y       = N_WIDTH'(32'h0000_0A00),
   parameter logic [N_WIDTH-1:0]   H_X       = N_WIDTH'(32'h0000_0A00),
   parameter logic [N_WIDTH-1:0]   H_Z       = N_WIDTH'(32'h0005_0000),
   parameter logic [N_WIDTH-1:0]   SAT_LIN   = N_WIDTH'(32'h0000_4000),
   parameter logic [N_WIDTH-1:0]   SAT_ANG   = N_WIDTH'(32'h000F_0000),
   parameter int unsigned          SETTLE_N  = 8,
   parameter int unsigned          TIMEOUT_N = 50000000
) (
   input  logic               ERROR_SEQUENCER_CLOCK_50,
   input  logic               ERROR_SEQUENCER_RESET_InHigh,
   input  logic               ERROR_SEQUENCER_ENABLE_In,
   input  logic               ERROR_SEQUENCER_VALID_In,
   input  logic [N_WIDTH-1:0] ERROR_SEQUENCER_X_InBus,
   input  logic [N_WIDTH-1:0] ERROR_SEQUENCER_Y_InBus,
   input  logic [N_WIDTH-1:0] ERROR_SEQUENCER_Z_InBus,
   output logic [N_WIDTH-1:0] ERROR_SEQUENCER_VX_OutBus,
   output logic [N_WIDTH-1:0] ERROR_SEQUENCER_VY_OutBus,
   output logic [N_WIDTH-1:0] ERROR_SEQUENCER_WZ_OutBus,
   output logic               ERROR_SEQUENCER_VALID_Out,
   output logic [2:0]         ERROR_SEQUENCER_STATE_OutBus,
   output logic               ERROR_SEQUENCER_DONE_Out,
   output logic               ERROR_SEQUENCER_FAULT_Out
);

   localparam int unsigned MW = N_WIDTH - 1;
   localparam int unsigned SW = $clog2(SETTLE_N + 1);
   localparam int unsigned TW = $clog2(TIMEOUT_N + 1);

   if (Q_WIDTH >= MW || SETTLE_N < 1 || TIMEOUT_N < 1) begin : g_bad_param
      $error("error_sequencer: illegal parameter combination");
   end

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ALIGN_Y = 3'd1,
      S_ALIGN_X = 3'd2,
      S_ALIGN_Z = 3'd3,
      S_DONE    = 3'd4,
      S_FAULT   = 3'd5
   } state_t;

   state_t               state;
   logic [SW-1:0]        settle_cnt;
   logic [TW-1:0]        time_cnt;
   logic [N_WIDTH-1:0]   err_sel;
   logic [N_WIDTH-1:0]   band_sel;
   state_t               next_align;

   function automatic logic in_band(input logic [N_WIDTH-1:0] e, input logic [N_WIDTH-1:0] h);
      return e[MW-1:0] <= h[MW-1:0];
   endfunction

   // Strictly beyond twice the band; computed one bit wider so 2*H cannot overflow.
   function automatic logic beyond_2h(input logic [N_WIDTH-1:0] e, input logic [N_WIDTH-1:0] h);
      return {1'b0, e[MW-1:0]} > {h[MW-1:0], 1'b0};
   endfunction

   // Clamp magnitude, copy (optionally invert) sign; zero magnitude is always +0.
   function automatic logic [N_WIDTH-1:0] sat(input logic [N_WIDTH-1:0] e,
                                              input logic [N_WIDTH-1:0] lim,
                                              input logic               inv);
      logic [MW-1:0] m;
      m = (e[MW-1:0] > lim[MW-1:0]) ? lim[MW-1:0] : e[MW-1:0];
      return {(m != '0) & (e[N_WIDTH-1] ^ inv), m};
   endfunction

   // Error bus, band and successor for whichever axis is being aligned.
   always_comb begin
      err_sel    = ERROR_SEQUENCER_Y_InBus;
      band_sel   = H_Y;
      next_align = S_ALIGN_X;
      case (state)
         S_ALIGN_X: begin
            err_sel    = ERROR_SEQUENCER_X_InBus;
            band_sel   = H_X;
            next_align = S_ALIGN_Z;
         end
         S_ALIGN_Z: begin
            err_sel    = ERROR_SEQUENCER_Z_InBus;
            band_sel   = H_Z;
            next_align = S_DONE;
         end
         default: ;
      endcase
   end

   always_ff @(posedge ERROR_SEQUENCER_CLOCK_50 or posedge ERROR_SEQUENCER_RESET_InHigh) begin
      if (ERROR_SEQUENCER_RESET_InHigh) begin
         state                     <= S_IDLE;
         settle_cnt                <= '0;
         time_cnt                  <= '0;
         ERROR_SEQUENCER_VX_OutBus <= '0;
         ERROR_SEQUENCER_VY_OutBus <= '0;
         ERROR_SEQUENCER_WZ_OutBus <= '0;
         ERROR_SEQUENCER_VALID_Out <= 1'b0;
         ERROR_SEQUENCER_DONE_Out  <= 1'b0;
         ERROR_SEQUENCER_FAULT_Out <= 1'b0;
      end else begin
         ERROR_SEQUENCER_VALID_Out <= 1'b0;
         ERROR_SEQUENCER_DONE_Out  <= 1'b0;
         ERROR_SEQUENCER_FAULT_Out <= 1'b0;
         if (!ERROR_SEQUENCER_ENABLE_In) begin
            state                     <= S_IDLE;
            settle_cnt                <= '0;
            time_cnt                  <= '0;
            ERROR_SEQUENCER_VX_OutBus <= '0;
            ERROR_SEQUENCER_VY_OutBus <= '0;
            ERROR_SEQUENCER_WZ_OutBus <= '0;
         end else begin
            case (state)
               S_IDLE: begin
                  state                     <= S_ALIGN_Y;
                  settle_cnt                <= '0;
                  time_cnt                  <= '0;
                  ERROR_SEQUENCER_VX_OutBus <= '0;
                  ERROR_SEQUENCER_VY_OutBus <= '0;
                  ERROR_SEQUENCER_WZ_OutBus <= '0;
               end
               S_ALIGN_Y, S_ALIGN_X, S_ALIGN_Z: begin
                  if (time_cnt == TW'(TIMEOUT_N - 1)) begin
                     state                     <= S_FAULT;
                     ERROR_SEQUENCER_FAULT_Out <= 1'b1;
                     settle_cnt                <= '0;
                     time_cnt                  <= '0;
                     ERROR_SEQUENCER_VX_OutBus <= '0;
                     ERROR_SEQUENCER_VY_OutBus <= '0;
                     ERROR_SEQUENCER_WZ_OutBus <= '0;
                  end else begin
                     time_cnt <= time_cnt + TW'(1);
                     if (ERROR_SEQUENCER_VALID_In) begin
                        ERROR_SEQUENCER_VALID_Out <= 1'b1;
                        ERROR_SEQUENCER_VX_OutBus <= '0;
                        ERROR_SEQUENCER_VY_OutBus <= '0;
                        ERROR_SEQUENCER_WZ_OutBus <= '0;
                        if (!in_band(err_sel, band_sel)) begin
                           settle_cnt <= '0;
                           case (state)
                              S_ALIGN_Y: ERROR_SEQUENCER_VX_OutBus <= sat(err_sel, SAT_LIN, 1'b0);
                              S_ALIGN_X: ERROR_SEQUENCER_VY_OutBus <= sat(err_sel, SAT_LIN, 1'b1);
                              default:   ERROR_SEQUENCER_WZ_OutBus <= sat(err_sel, SAT_ANG, 1'b0);
                           endcase
                        end else if (settle_cnt == SW'(SETTLE_N - 1)) begin
                           state                    <= next_align;
                           settle_cnt               <= '0;
                           time_cnt                 <= '0;
                           ERROR_SEQUENCER_DONE_Out <= (next_align == S_DONE);
                        end else begin
                           settle_cnt <= settle_cnt + SW'(1);
                        end
                     end
                  end
               end
               S_DONE: begin
                  ERROR_SEQUENCER_DONE_Out <= 1'b1;
                  if (ERROR_SEQUENCER_VALID_In) begin
                     ERROR_SEQUENCER_VALID_Out <= 1'b1;
                     ERROR_SEQUENCER_VX_OutBus <= '0;
                     ERROR_SEQUENCER_VY_OutBus <= '0;
                     ERROR_SEQUENCER_WZ_OutBus <= '0;
                     if (beyond_2h(ERROR_SEQUENCER_Y_InBus, H_Y) ||
                         beyond_2h(ERROR_SEQUENCER_X_InBus, H_X) ||
                         beyond_2h(ERROR_SEQUENCER_Z_InBus, H_Z)) begin
                        state                    <= S_ALIGN_Y;
                        settle_cnt               <= '0;
                        time_cnt                 <= '0;
                        ERROR_SEQUENCER_DONE_Out <= 1'b0;
                     end
                  end
               end
               S_FAULT: begin
                  ERROR_SEQUENCER_FAULT_Out <= 1'b1;
                  ERROR_SEQUENCER_VX_OutBus <= '0;
                  ERROR_SEQUENCER_VY_OutBus <= '0;
                  ERROR_SEQUENCER_WZ_OutBus <= '0;
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

   assign ERROR_SEQUENCER_STATE_OutBus = state;

endmodule

// File: tb/tb_error_sequencer.sv
// Bench for error_sequencer: directed scenario tasks plus a randomized run
// against a behavioural model of the alignment sequence.
module tb_error_sequencer;

   localparam int unsigned        TO_MAIN = 300;
   localparam int unsigned        TO_T    = 20;
   localparam int unsigned        SETTLE  = 8;
   localparam logic [31:0]        HY = 32'h0000_0A00, HX = 32'h0000_0A00, HZ = 32'h0005_0000;
   localparam logic [31:0]        SLIN = 32'h0000_4000, SANG = 32'h000F_0000;

   logic        clk = 1'b0;
   logic        rst, en, vin;
   logic [31:0] x, y, z;
   logic [31:0] vx, vy, wz, t_vx, t_vy, t_wz;
   logic [2:0]  st, t_st;
   logic        vo, done, fault, t_vo, t_done, t_fault;

   int n_chk = 0;
   int n_fail = 0;

   // reference model state
   int          r_st, r_s, r_t;
   logic [31:0] r_vx, r_vy, r_wz;
   logic        r_vo;

   always #5 clk = ~clk;

   error_sequencer #(.TIMEOUT_N(TO_MAIN)) dut (
      .ERROR_SEQUENCER_CLOCK_50(clk), .ERROR_SEQUENCER_RESET_InHigh(rst),
      .ERROR_SEQUENCER_ENABLE_In(en), .ERROR_SEQUENCER_VALID_In(vin),
      .ERROR_SEQUENCER_X_InBus(x), .ERROR_SEQUENCER_Y_InBus(y), .ERROR_SEQUENCER_Z_InBus(z),
      .ERROR_SEQUENCER_VX_OutBus(vx), .ERROR_SEQUENCER_VY_OutBus(vy), .ERROR_SEQUENCER_WZ_OutBus(wz),
      .ERROR_SEQUENCER_VALID_Out(vo), .ERROR_SEQUENCER_STATE_OutBus(st),
      .ERROR_SEQUENCER_DONE_Out(done), .ERROR_SEQUENCER_FAULT_Out(fault));

   error_sequencer #(.TIMEOUT_N(TO_T)) dut_t (
      .ERROR_SEQUENCER_CLOCK_50(clk), .ERROR_SEQUENCER_RESET_InHigh(rst),
      .ERROR_SEQUENCER_ENABLE_In(en), .ERROR_SEQUENCER_VALID_In(vin),
      .ERROR_SEQUENCER_X_InBus(x), .ERROR_SEQUENCER_Y_InBus(y), .ERROR_SEQUENCER_Z_InBus(z),
      .ERROR_SEQUENCER_VX_OutBus(t_vx), .ERROR_SEQUENCER_VY_OutBus(t_vy), .ERROR_SEQUENCER_WZ_OutBus(t_wz),
      .ERROR_SEQUENCER_VALID_Out(t_vo), .ERROR_SEQUENCER_STATE_OutBus(t_st),
      .ERROR_SEQUENCER_DONE_Out(t_done), .ERROR_SEQUENCER_FAULT_Out(t_fault));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int unsigned mag(input logic [31:0] v);
      return int'(v & 32'h7FFF_FFFF);
   endfunction

   function automatic logic [31:0] satv(input logic [31:0] v, input logic [31:0] lim, input bit inv);
      int unsigned m;
      m = (mag(v) < mag(lim)) ? mag(v) : mag(lim);
      if (m == 0) return 32'h0;
      return {v[31] ^ inv, m[30:0]};
   endfunction

   // Model: one clock of the alignment sequence, written from the behavioural rules.
   task automatic model_step(input bit e, input bit s, input logic [31:0] xi, yi, zi);
      logic [31:0] err;
      int unsigned h;
      r_vo = 1'b0;
      if (!e) begin
         r_st = 0; r_s = 0; r_t = 0; r_vx = 0; r_vy = 0; r_wz = 0;
      end else if (r_st == 0) begin
         r_st = 1; r_s = 0; r_t = 0; r_vx = 0; r_vy = 0; r_wz = 0;
      end else if (r_st >= 1 && r_st <= 3) begin
         if (r_t + 1 >= int'(TO_MAIN)) begin
            r_st = 5; r_s = 0; r_t = 0; r_vx = 0; r_vy = 0; r_wz = 0;
         end else begin
            r_t++;
            if (s) begin
               r_vo = 1'b1; r_vx = 0; r_vy = 0; r_wz = 0;
               err = (r_st == 1) ? yi : (r_st == 2) ? xi : zi;
               h   = (r_st == 1) ? mag(HY) : (r_st == 2) ? mag(HX) : mag(HZ);
               if (mag(err) > h) begin
                  r_s = 0;
                  if (r_st == 1) r_vx = satv(yi, SLIN, 1'b0);
                  else if (r_st == 2) r_vy = satv(xi, SLIN, 1'b1);
                  else r_wz = satv(zi, SANG, 1'b0);
               end else begin
                  r_s++;
                  if (r_s == int'(SETTLE)) begin
                     r_st++; r_s = 0; r_t = 0;
                  end
               end
            end
         end
      end else if (r_st == 4) begin
         if (s) begin
            r_vo = 1'b1; r_vx = 0; r_vy = 0; r_wz = 0;
            if (longint'(mag(yi)) > 2 * longint'(mag(HY)) || longint'(mag(xi)) > 2 * longint'(mag(HX)) ||
                longint'(mag(zi)) > 2 * longint'(mag(HZ))) begin
               r_st = 1; r_s = 0; r_t = 0;
            end
         end
      end else begin
         r_vx = 0; r_vy = 0; r_wz = 0;
      end
   endtask

   function automatic logic [31:0] rnd_err(input logic [31:0] h);
      int unsigned r, m;
      r = $urandom_range(0, 19);
      if (r < 17)       m = $urandom_range(0, mag(h));
      else if (r == 17) m = mag(h) + 1;
      else if (r == 18) m = $urandom_range(mag(h) + 1, 2 * mag(h) + 1);
      else              m = $urandom & 32'h7FFF_FFFF;
      return {1'($urandom_range(0, 1)), m[30:0]};
   endfunction

   task automatic test_reset();
      rst = 1'b0; en = 1'b0; vin = 1'b0; x = 0; y = 0; z = 0;
      #1 rst = 1'b1;
      #1;
      n_chk++; if (st !== 3'd0) begin n_fail++; $display("FAIL reset_state got=%0d exp=0", st); end
      n_chk++; if ({vx, vy, wz} !== 96'h0) begin n_fail++; $display("FAIL reset_outputs got=%h %h %h exp=0", vx, vy, wz); end
      n_chk++; if ({vo, done, fault} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got=%b exp=000", {vo, done, fault}); end
      step(); step();
      rst = 1'b0;
      step();
      n_chk++; if (st !== 3'd0) begin n_fail++; $display("FAIL reset_idle_hold got=%0d exp=0", st); end
   endtask

   task automatic test_basic();
      en = 1'b1; vin = 1'b1; y = 32'h0000_2000;
      step();
      n_chk++; if (st !== 3'd1 || vo !== 1'b0) begin n_fail++; $display("FAIL basic_entry state=%0d vo=%b exp=1 0", st, vo); end
      step(); vin = 1'b0;
      n_chk++; if ({vx, vy, wz} !== {32'h0000_2000, 64'h0}) begin n_fail++; $display("FAIL basic_vx got=%h %h %h exp=00002000 0 0", vx, vy, wz); end
      n_chk++; if (vo !== 1'b1 || st !== 3'd1) begin n_fail++; $display("FAIL basic_valid vo=%b state=%0d exp=1 1", vo, st); end
      step();
      n_chk++; if (vo !== 1'b0 || vx !== 32'h0000_2000) begin n_fail++; $display("FAIL basic_hold vo=%b vx=%h exp=0 00002000", vo, vx); end
      y = 32'h8001_0000; vin = 1'b1; step(); vin = 1'b0;
      n_chk++; if (vx !== 32'h8000_4000) begin n_fail++; $display("FAIL basic_sat_neg got=%h exp=80004000", vx); end
      y = 32'h0000_0A01; vin = 1'b1; step(); vin = 1'b0;
      n_chk++; if (vx !== 32'h0000_0A01) begin n_fail++; $display("FAIL basic_band_edge got=%h exp=00000a01", vx); end
   endtask

   task automatic test_settle();
      y = 32'h8000_0000; vin = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step();
         n_chk++;
         if (st !== ((i == 7) ? 3'd2 : 3'd1) || vx !== 32'h0 || vo !== 1'b1) begin
            n_fail++; $display("FAIL settle_y[%0d] state=%0d vx=%h vo=%b", i, st, vx, vo);
         end
      end
      x = 32'h0000_3000; step();
      n_chk++; if ({vx, vy, wz} !== {32'h0, 32'h8000_3000, 32'h0}) begin n_fail++; $display("FAIL settle_vy_inv got=%h %h %h exp=0 80003000 0", vx, vy, wz); end
      x = 32'h8000_3000; step();
      n_chk++; if (vy !== 32'h0000_3000) begin n_fail++; $display("FAIL settle_vy_pos got=%h exp=00003000", vy); end
      x = 32'h0000_0A00;
      for (int i = 0; i < 8; i++) step();
      n_chk++; if (st !== 3'd3 || vy !== 32'h0) begin n_fail++; $display("FAIL settle_x state=%0d vy=%h exp=3 0", st, vy); end
   endtask

   task automatic test_done();
      x = 0; y = 0; z = 32'h8010_0000; step();
      n_chk++; if (wz !== 32'h800F_0000 || st !== 3'd3) begin n_fail++; $display("FAIL done_wz_sat wz=%h state=%0d exp=800f0000 3", wz, st); end
      for (int i = 0; i < 8; i++) begin
         z = (i % 2 == 0) ? 32'h0005_0000 : 32'h8005_0000;
         step();
      end
      n_chk++; if (st !== 3'd4 || done !== 1'b1 || wz !== 32'h0) begin n_fail++; $display("FAIL done_enter state=%0d done=%b wz=%h", st, done, wz); end
      z = 32'h000A_0000; step();
      n_chk++; if (st !== 3'd4 || vo !== 1'b1 || done !== 1'b1) begin n_fail++; $display("FAIL done_2h_stay state=%0d vo=%b done=%b", st, vo, done); end
      z = 32'h0015_0000; step(); vin = 1'b0;
      n_chk++; if (st !== 3'd1 || done !== 1'b0 || {vx, vy, wz} !== 96'h0) begin n_fail++; $display("FAIL done_reenter state=%0d done=%b wz=%h", st, done, wz); end
   endtask

   task automatic test_timeout();
      en = 1'b0; step();
      n_chk++; if (t_st !== 3'd0) begin n_fail++; $display("FAIL to_idle got=%0d exp=0", t_st); end
      en = 1'b1; y = 32'h0001_0000; vin = 1'b1; step();
      for (int k = 1; k < int'(TO_T); k++) step();
      n_chk++; if (t_st !== 3'd1 || t_vx !== 32'h0000_4000) begin n_fail++; $display("FAIL to_before state=%0d vx=%h exp=1 00004000", t_st, t_vx); end
      step();
      n_chk++; if (t_st !== 3'd5 || t_fault !== 1'b1 || t_vx !== 32'h0 || t_vo !== 1'b0) begin
         n_fail++; $display("FAIL to_fault state=%0d fault=%b vx=%h vo=%b", t_st, t_fault, t_vx, t_vo);
      end
      step();
      n_chk++; if (t_st !== 3'd5 || t_vo !== 1'b0) begin n_fail++; $display("FAIL to_stick state=%0d vo=%b", t_st, t_vo); end
      en = 1'b0; vin = 1'b0; step();
      n_chk++; if (t_st !== 3'd0 || t_fault !== 1'b0) begin n_fail++; $display("FAIL to_exit state=%0d fault=%b", t_st, t_fault); end
   endtask

   task automatic test_async_reset();
      en = 1'b1; x = 0; y = 0; z = 0; step();
      vin = 1'b1;
      for (int i = 0; i < 8; i++) step();
      x = 32'h0000_1000; step(); vin = 1'b0;
      n_chk++; if (st !== 3'd2 || vy !== 32'h8000_1000) begin n_fail++; $display("FAIL ar_setup state=%0d vy=%h exp=2 80001000", st, vy); end
      #3 rst = 1'b1;
      #1;
      n_chk++; if (st !== 3'd0 || vy !== 32'h0 || vo !== 1'b0) begin n_fail++; $display("FAIL ar_immediate state=%0d vy=%h vo=%b", st, vy, vo); end
      #2 rst = 1'b0;
      y = 32'h0000_1000; vin = 1'b1; step();
      n_chk++; if (st !== 3'd1 || vo !== 1'b0 || vx !== 32'h0) begin n_fail++; $display("FAIL ar_restart state=%0d vo=%b vx=%h", st, vo, vx); end
      step(); vin = 1'b0;
      n_chk++; if (vo !== 1'b1 || vx !== 32'h0000_1000) begin n_fail++; $display("FAIL ar_first_sample vo=%b vx=%h", vo, vx); end
   endtask

   task automatic test_random();
      bit          e, s;
      logic [31:0] xi, yi, zi;
      rst = 1'b1; en = 1'b0; vin = 1'b0; step(); rst = 1'b0;
      r_st = 0; r_s = 0; r_t = 0; r_vx = 0; r_vy = 0; r_wz = 0; r_vo = 1'b0;
      for (int c = 0; c < 6000; c++) begin
         e  = ($urandom_range(0, 149) != 0);
         s  = ($urandom_range(0, 2) != 0);
         xi = rnd_err(HX); yi = rnd_err(HY); zi = rnd_err(HZ);
         en = e; vin = s; x = xi; y = yi; z = zi;
         step();
         model_step(e, s, xi, yi, zi);
         n_chk++;
         if (st !== 3'(r_st) || vx !== r_vx || vy !== r_vy || wz !== r_wz || vo !== r_vo ||
             done !== (r_st == 4) || fault !== (r_st == 5)) begin
            n_fail++;
            $display("FAIL random[%0d] got st=%0d vx=%h vy=%h wz=%h vo=%b d=%b f=%b exp st=%0d vx=%h vy=%h wz=%h vo=%b",
                     c, st, vx, vy, wz, vo, done, fault, r_st, r_vx, r_vy, r_wz, r_vo);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_settle();
      test_done();
      test_timeout();
      test_async_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
